// File: rtl/jtldtest_rdcheck_if.sv
// Bank read port bundle shared by the read-back checker (master) and the SDRAM controller (slave).
interface jtldtest_rdcheck_if;
    logic [3:0]  ba_rd;
    logic [21:0] ba_addr;
    logic [3:0]  ba_ack;
    logic [3:0]  ba_rdy;
    logic [15:0] data_read;

    modport master (output ba_rd, ba_addr, input ba_ack, ba_rdy, data_read);
    modport slave  (input ba_rd, ba_addr, output ba_ack, ba_rdy, data_read);
endinterface

// File: rtl/jtldtest_rdcheck.sv
// SDRAM load-test read-back verifier: per-bank byte checksum during download, then read-back and compare.
// Optional JTLDTEST_REPEAT_EN: re-run the verification pass on every LVBL falling edge once done.
module jtldtest_rdcheck #(
    parameter int TOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                LVBL,
    input  logic                downloading,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic                ioctl_wr,
    jtldtest_rdcheck_if.master  sdram,
    output logic [3:0]          ba_bad,
    output logic                bad,
    output logic                done,
    output logic [7:0]          pass_cnt
);

    typedef enum logic [2:0] {IDLE, LOAD, START, REQ, WAIT, CMP, DONE} state_t;

    state_t            st;
    logic [3:0][15:0]  dsum;
    logic [3:0][22:0]  maxa;
    logic [3:0]        used;
    logic [15:0]       rsum;
    logic [21:0]       w;
    logic [1:0]        bank;
    logic [15:0]       tcnt;
    logic              skip_cmp;
    logic              dl_last;
    logic              dl_rise;
    logic [1:0]        wr_bank;
    logic [21:0]       last_w;
    logic              last_half;

    assign dl_rise   = downloading & ~dl_last;
    assign wr_bank   = ioctl_addr[24:23];
    assign last_w    = maxa[bank][22:1];
    // An even highest byte address means the final word carries only its low byte
    assign last_half = ~maxa[bank][0];
    assign bad       = |ba_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsum <= '0;
            maxa <= '0;
            used <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (dl_rise) begin
                    dsum[b] <= '0;
                    maxa[b] <= '0;
                    used[b] <= 1'b0;
                end
                if (ioctl_wr && downloading && wr_bank == 2'(b)) begin
                    dsum[b] <= (dl_rise ? 16'd0 : dsum[b]) + {8'd0, ioctl_dout};
                    maxa[b] <= (dl_rise || ioctl_addr[22:0] > maxa[b]) ? ioctl_addr[22:0] : maxa[b];
                    used[b] <= 1'b1;
                end
            end
        end
    end

`ifdef JTLDTEST_REPEAT_EN
    logic lvbl_last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvbl_last <= 1'b0;
        else        lvbl_last <= LVBL;
    end
`else
    logic unused_lvbl;
    assign unused_lvbl = LVBL;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            sdram.ba_rd   <= '0;
            sdram.ba_addr <= '0;
            ba_bad        <= '0;
            done          <= 1'b0;
            pass_cnt      <= '0;
            rsum          <= '0;
            w             <= '0;
            bank          <= '0;
            tcnt          <= '0;
            skip_cmp      <= 1'b0;
            dl_last       <= 1'b0;
        end else begin
            dl_last <= downloading;
            // A new download wins over whatever the pass was doing
            if (dl_rise) begin
                st          <= LOAD;
                sdram.ba_rd <= '0;
                ba_bad      <= '0;
                done        <= 1'b0;
                pass_cnt    <= '0;
            end else begin
                case (st)
                    IDLE: begin
                        if (downloading) st <= LOAD;
`ifdef JTLDTEST_REPEAT_EN
                        else if (done && lvbl_last && !LVBL) begin
                            bank <= '0;
                            st   <= START;
                        end
`endif
                    end
                    LOAD: begin
                        if (!downloading) begin
                            bank <= '0;
                            st   <= START;
                        end
                    end
                    START: begin
                        rsum     <= '0;
                        w        <= '0;
                        skip_cmp <= 1'b0;
                        if (used[bank])        st   <= REQ;
                        else if (bank == 2'd3) st   <= DONE;
                        else                   bank <= bank + 2'd1;
                    end
                    REQ: begin
                        sdram.ba_addr <= w;
                        sdram.ba_rd   <= 4'b0001 << bank;
                        tcnt          <= '0;
                        st            <= WAIT;
                    end
                    WAIT: begin
                        if (sdram.ba_ack[bank]) sdram.ba_rd <= '0;
                        if (sdram.ba_rdy[bank]) begin
                            sdram.ba_rd <= '0;
                            rsum <= rsum + {8'd0, sdram.data_read[7:0]}
                                 + ((w == last_w && last_half) ? 16'd0 : {8'd0, sdram.data_read[15:8]});
                            if (w == last_w) st <= CMP;
                            else begin
                                w  <= w + 22'd1;
                                st <= REQ;
                            end
                        end else if (tcnt == 16'(TOUT - 1)) begin
                            ba_bad[bank] <= 1'b1;
                            skip_cmp     <= 1'b1;
                            sdram.ba_rd  <= '0;
                            st           <= CMP;
                        end else begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                    CMP: begin
                        if (!skip_cmp && rsum != dsum[bank]) ba_bad[bank] <= 1'b1;
                        if (bank == 2'd3) st <= DONE;
                        else begin
                            bank <= bank + 2'd1;
                            st   <= START;
                        end
                    end
                    DONE: begin
                        done     <= 1'b1;
                        pass_cnt <= pass_cnt + 8'd1;
                        st       <= IDLE;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtldtest_rdcheck.sv
// Randomized bench for jtldtest_rdcheck: SDRAM bank model plus a checksum/read-sequence reference.
module tb_jtldtest_rdcheck;
    localparam int TOUT = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        LVBL = 1'b1;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wr = 1'b0;
    logic [3:0]  ba_bad;
    logic        bad;
    logic        done;
    logic [7:0]  pass_cnt;

    jtldtest_rdcheck_if sdram();

    jtldtest_rdcheck #(.TOUT(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .sdram(sdram), .ba_bad(ba_bad), .bad(bad), .done(done), .pass_cnt(pass_cnt)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_b [4][128];
    logic [15:0] corr  [4][64];
    int          dl_len [4];
    bit          tout_bank [4];
    logic [23:0] rd_log [$];
    logic [23:0] exp_log [$];
    int          onehot_err = 0;
    int          addr_err = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] memWord(int b, int a);
        return {mem_b[b][2*a+1], mem_b[b][2*a]} ^ corr[b][a];
    endfunction

    // Expected flags: a loaded bank is bad if its read never completes or the
    // bytes read back over the loaded range do not sum to the downloaded bytes
    function automatic logic [3:0] refBad();
        logic [3:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            if (dl_len[b] > 0) begin
                if (tout_bank[b]) r[b] = 1'b1;
                else begin
                    int ds;
                    int rs;
                    logic [15:0] wd;
                    ds = 0;
                    rs = 0;
                    for (int i = 0; i < dl_len[b]; i++) begin
                        ds += int'(mem_b[b][i]);
                        wd = memWord(b, i / 2);
                        rs += (i % 2 == 1) ? int'(wd[15:8]) : int'(wd[7:0]);
                    end
                    if ((ds % 65536) != (rs % 65536)) r[b] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic buildExp();
        int n;
        exp_log.delete();
        for (int b = 0; b < 4; b++) begin
            if (dl_len[b] > 0) begin
                n = tout_bank[b] ? 1 : (dl_len[b] + 1) / 2;
                for (int wi = 0; wi < n; wi++) exp_log.push_back({2'(b), 22'(wi)});
            end
        end
    endtask

    // SDRAM bank model: random ack and data latency, logs every request
    int          ms = 0;
    logic [1:0]  mbank;
    logic [21:0] maddr;
    int          ack_d;
    int          rdy_d;
    always @(negedge clk) begin
        sdram.ba_ack = '0;
        sdram.ba_rdy = '0;
        if (!rst_n || downloading) begin
            ms = 0;
            sdram.data_read = '0;
        end else begin
            if ($countones(sdram.ba_rd) > 1) onehot_err++;
            if (ms == 0 && sdram.ba_rd != '0) begin
                for (int b = 3; b >= 0; b--) if (sdram.ba_rd[b]) mbank = 2'(b);
                maddr = sdram.ba_addr;
                rd_log.push_back({mbank, maddr});
                ack_d = $urandom_range(0, 2);
                rdy_d = $urandom_range(0, 3);
                ms = 1;
            end
            if (ms > 0 && sdram.ba_addr != maddr) addr_err++;
            if (ms == 1) begin
                if (ack_d == 0) begin
                    sdram.ba_ack[mbank] = 1'b1;
                    ms = 2;
                end else ack_d--;
            end
            if (ms == 2) begin
                if (rdy_d == 0) begin
                    if (!tout_bank[mbank]) begin
                        sdram.ba_rdy[mbank] = 1'b1;
                        sdram.data_read = (maddr < 22'd64) ? memWord(int'(mbank), int'(maddr)) : 16'hDEAD;
                    end
                    ms = 0;
                end else rdy_d--;
            end
        end
    end

    task automatic prepareLoad(input int l0, input int l1, input int l2, input int l3);
        dl_len[0] = l0; dl_len[1] = l1; dl_len[2] = l2; dl_len[3] = l3;
        for (int b = 0; b < 4; b++) begin
            tout_bank[b] = 1'b0;
            for (int i = 0; i < 128; i++) mem_b[b][i] = (i < dl_len[b]) ? 8'($urandom) : 8'hFF;
            for (int i = 0; i < 64; i++) corr[b][i] = '0;
        end
    endtask

    // Download every loaded byte in shuffled order
    task automatic applyStimulus();
        int idx [$];
        int j;
        int tmp;
        @(negedge clk);
        downloading = 1'b1;
        rd_log.delete();
        onehot_err = 0;
        addr_err = 0;
        repeat (2) @(negedge clk);
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < dl_len[b]; i++) idx.push_back(b * 128 + i);
        for (int i = idx.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = idx[i]; idx[i] = idx[j]; idx[j] = tmp;
        end
        foreach (idx[k]) begin
            ioctl_addr = {2'(idx[k] / 128), 23'(idx[k] % 128)};
            ioctl_dout = mem_b[idx[k] / 128][idx[k] % 128];
            ioctl_wr = 1'b1;
            @(negedge clk);
            ioctl_wr = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        @(negedge clk);
        downloading = 1'b0;
    endtask

    task automatic waitPass(input string tag, input int expc);
        int n;
        n = 0;
        while (int'(pass_cnt) != expc && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_pass_cnt"}, 32'(pass_cnt), 32'(expc));
    endtask

    task automatic checkLog(input string tag, input int reps);
        int nbad;
        nbad = 0;
        checkOutput({tag, "_rd_count"}, 32'(rd_log.size()), 32'(reps * exp_log.size()));
        if (exp_log.size() > 0)
            foreach (rd_log[i]) if (rd_log[i] !== exp_log[i % exp_log.size()]) nbad++;
        checkOutput({tag, "_rd_seq"}, 32'(nbad), 32'd0);
    endtask

    task automatic checkResult(input string tag);
        logic [3:0] eb;
        eb = refBad();
        buildExp();
        checkOutput({tag, "_ba_bad"}, 32'(ba_bad), 32'(eb));
        checkOutput({tag, "_bad"}, 32'(bad), 32'(|eb));
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkLog(tag, 1);
        checkOutput({tag, "_onehot"}, 32'(onehot_err), 32'd0);
        checkOutput({tag, "_addr_hold"}, 32'(addr_err), 32'd0);
    endtask

    task automatic waitRd(input string tag, input int b);
        int n;
        n = 0;
        while (!sdram.ba_rd[b] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_rd_seen"}, 32'(sdram.ba_rd[b]), 32'd1);
    endtask

    initial begin
        int n;
        int len;
        int wi;

        repeat (3) @(negedge clk);
        checkOutput("rst_ba_rd", 32'(sdram.ba_rd), 32'd0);
        checkOutput("rst_ba_addr", 32'(sdram.ba_addr), 32'd0);
        checkOutput("rst_ba_bad", 32'(ba_bad), 32'd0);
        checkOutput("rst_bad", 32'(bad), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] even-length match on bank 0");
        prepareLoad(4, 0, 0, 0);
        mem_b[0][0] = 8'h11; mem_b[0][1] = 8'h22; mem_b[0][2] = 8'h33; mem_b[0][3] = 8'h44;
        applyStimulus();
        waitPass("even", 1);
        checkResult("even");
        checkOutput("even_exact_bad", 32'(ba_bad), 32'd0);

        $display("[TB] odd-length load on bank 2");
        prepareLoad(0, 0, 3, 0);
        applyStimulus();
        waitPass("odd", 1);
        checkResult("odd");

        $display("[TB] corrupted word on bank 1");
        prepareLoad(0, 64, 0, 0);
        corr[1][5] = 16'h0001;
        applyStimulus();
        waitPass("corrupt", 1);
        checkResult("corrupt");
        checkOutput("corrupt_exact_bad", 32'(ba_bad), 32'h2);

        $display("[TB] timeout on bank 3");
        prepareLoad(8, 0, 0, 6);
        tout_bank[3] = 1'b1;
        applyStimulus();
        waitRd("tout", 3);
        n = 0;
        while (!ba_bad[3] && n < TOUT + 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tout_cycles", 32'(n), 32'(TOUT));
        waitPass("tout", 1);
        checkResult("tout");

        for (int it = 0; it < 3; it++) begin
            $display("[TB] random multi-bank load %0d", it);
            prepareLoad(0, 0, 0, 0);
            for (int b = 0; b < 4; b++) begin
                len = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 64));
                dl_len[b] = len;
                for (int i = 0; i < len; i++) mem_b[b][i] = 8'($urandom);
                if (len > 0 && $urandom_range(0, 1) == 1) begin
                    wi = int'($urandom_range(0, (len + 1) / 2 - 1));
                    corr[b][wi] = 16'(1 << $urandom_range(0, 15));
                end
            end
            applyStimulus();
            waitPass("rand", 1);
            checkResult("rand");
        end

        $display("[TB] LVBL re-check behaviour");
        prepareLoad(10, 0, 5, 0);
        corr[2][0] = 16'h0004;
        applyStimulus();
        waitPass("rep1", 1);
        checkResult("rep1");
        for (int k = 2; k <= 4; k++) begin
            LVBL = 1'b0;
            repeat (3) @(negedge clk);
            LVBL = 1'b1;
`ifdef JTLDTEST_REPEAT_EN
            waitPass("rep", k);
`else
            repeat (100) @(negedge clk);
`endif
        end
`ifdef JTLDTEST_REPEAT_EN
        checkOutput("rep_pass_cnt_final", 32'(pass_cnt), 32'd4);
        checkLog("rep", 4);
`else
        checkOutput("norep_pass_cnt_final", 32'(pass_cnt), 32'd1);
        checkLog("norep", 1);
`endif
        checkOutput("rep_sticky_bad", 32'(ba_bad), 32'(refBad()));

        $display("[TB] reset in the middle of a read");
        prepareLoad(16, 32, 0, 0);
        corr[0][2] = 16'h0100;
        applyStimulus();
        waitRd("midrst", 1);
        checkOutput("midrst_pre_bad", 32'(ba_bad), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_ba_rd", 32'(sdram.ba_rd), 32'd0);
        checkOutput("midrst_ba_addr", 32'(sdram.ba_addr), 32'd0);
        checkOutput("midrst_ba_bad", 32'(ba_bad), 32'd0);
        checkOutput("midrst_bad", 32'(bad), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_pass_cnt", 32'(pass_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] new download preempting a pass");
        prepareLoad(16, 32, 0, 0);
        corr[0][3] = 16'h0010;
        applyStimulus();
        waitRd("preempt", 1);
        checkOutput("preempt_pre_bad", 32'(ba_bad), 32'h1);
        downloading = 1'b1;
        @(negedge clk);
        checkOutput("preempt_ba_rd", 32'(sdram.ba_rd), 32'd0);
        checkOutput("preempt_ba_bad", 32'(ba_bad), 32'd0);
        checkOutput("preempt_done", 32'(done), 32'd0);
        checkOutput("preempt_pass_cnt", 32'(pass_cnt), 32'd0);
        prepareLoad(0, 12, 7, 0);
        applyStimulus();
        waitPass("after_preempt", 1);
        checkResult("after_preempt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
